// File: rtl/updi_pkg.sv
// ============================================================================
// Module : updi_pkg
// Brief  : UPDI opcode fields, link constants and target FSM state encoding.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package updi_pkg;

  localparam logic [7:0] UPDI_SYNCH = 8'h55;
  localparam logic [7:0] UPDI_ACK   = 8'h40;

  localparam logic [2:0] OP_LDS  = 3'b000;
  localparam logic [2:0] OP_STS  = 3'b010;
  localparam logic [2:0] OP_LDCS = 3'b100;
  localparam logic [2:0] OP_STCS = 3'b110;
  localparam logic [2:0] OP_KEY  = 3'b111;

  typedef enum logic [3:0] {
    SYNC     = 4'd0,
    OPCODE   = 4'd1,
    ADDR     = 4'd2,
    DATA_TX  = 4'd3,
    STS_ACK1 = 4'd4,
    DATA_RX  = 4'd5,
    STS_ACK2 = 4'd6,
    CS_TX    = 4'd7,
    CS_RX    = 4'd8,
    KEY_RX   = 4'd9,
    SIB_TX   = 4'd10,
    ERROR    = 4'd11
  } updi_target_state;

  // Maps an opcode byte to the state that handles its operands; ERROR if illegal.
  function automatic updi_target_state decode_op(input logic [7:0] op);
    updi_target_state st;
    st = ERROR;
    case (op[7:5])
      OP_LDS, OP_STS: if (op[3:2] != 2'd3 && op[1:0] <= 2'd1) st = ADDR;
      OP_LDCS:        st = CS_TX;
      OP_STCS:        st = CS_RX;
      OP_KEY:         if (op[1:0] == 2'd0) st = op[2] ? SIB_TX : KEY_RX;
      default:        st = ERROR;
    endcase
    return st;
  endfunction

endpackage

`default_nettype wire

// File: rtl/updi_target_mem.sv
// ============================================================================
// Module : updi_target_mem
// Brief  : Byte memory, one synchronous write port and two async read ports.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module updi_target_mem #(
  parameter int DEPTH     = 256,
  parameter int ADDR_BITS = 8
) (
  input  logic                 clk,
  input  logic                 we_i,
  input  logic [ADDR_BITS-1:0] waddr_i,
  input  logic [7:0]           wdata_i,
  input  logic [ADDR_BITS-1:0] raddr_i,
  output logic [7:0]           rdata_o,
  input  logic [ADDR_BITS-1:0] dbg_addr_i,
  output logic [7:0]           dbg_data_o
);

  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o    = mem_q[raddr_i];
  assign dbg_data_o = mem_q[dbg_addr_i];

endmodule

`default_nettype wire

// File: rtl/updi_target_responder.sv
// ============================================================================
// Module : updi_target_responder
// Brief  : UPDI device-side frame parser answering host frames via byte FIFOs.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module updi_target_responder
  import updi_pkg::*;
#(
  parameter int          MEM_DEPTH     = 256,
  parameter int          MEM_ADDR_BITS = $clog2(MEM_DEPTH),
  parameter logic [7:0]  STATUSA_RST   = 8'h30,
  parameter logic [63:0] SIB_VALUE     = 64'h2020_2020_2052_5641
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     double_break,
  input  logic [7:0]               rx_data,
  input  logic                     rx_empty,
  output logic                     rx_rd_en,
  output logic [7:0]               tx_data,
  output logic                     tx_wr_en,
  input  logic                     tx_full,
  output logic                     key_strobe,
  output logic [63:0]              key_value,
  output logic                     frame_error,
  input  logic [MEM_ADDR_BITS-1:0] dbg_addr,
  output logic [7:0]               dbg_data
);

  updi_target_state state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [7:0]       op_q, op_d;
  logic [23:0]      addr_q, addr_d;
  logic [63:0]      key_q, key_d;
  logic             ferr_q, ferr_d;
  logic [15:0][7:0] cs_q, cs_d;

  logic                     mem_we;
  logic [MEM_ADDR_BITS-1:0] mem_idx;
  logic [7:0]               mem_rdata;
  logic                     can_pop, can_push;
  logic                     unused_bits;

  assign can_pop     = !rx_empty;
  assign can_push    = !tx_full;
  assign mem_idx     = addr_q[MEM_ADDR_BITS-1:0] + MEM_ADDR_BITS'(cnt_q);
  assign unused_bits = ^{addr_q[23:MEM_ADDR_BITS], op_q[4]};

  updi_target_mem #(
    .DEPTH     (MEM_DEPTH),
    .ADDR_BITS (MEM_ADDR_BITS)
  ) u_mem (
    .clk        (clk),
    .we_i       (mem_we),
    .waddr_i    (mem_idx),
    .wdata_i    (rx_data),
    .raddr_i    (mem_idx),
    .rdata_o    (mem_rdata),
    .dbg_addr_i (dbg_addr),
    .dbg_data_o (dbg_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= SYNC;
      cnt_q    <= '0;
      op_q     <= '0;
      addr_q   <= '0;
      key_q    <= '0;
      ferr_q   <= 1'b0;
      cs_q     <= '0;
      cs_q[0]  <= STATUSA_RST;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      key_q    <= key_d;
      ferr_q   <= ferr_d;
      cs_q     <= cs_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    addr_d     = addr_q;
    key_d      = key_q;
    ferr_d     = ferr_q;
    cs_d       = cs_q;
    rx_rd_en   = 1'b0;
    tx_wr_en   = 1'b0;
    tx_data    = 8'h00;
    key_strobe = 1'b0;
    mem_we     = 1'b0;

    case (state_q)
      SYNC, OPCODE, ADDR, DATA_RX, CS_RX, KEY_RX, ERROR: rx_rd_en = can_pop;
      default: rx_rd_en = 1'b0;
    endcase

    case (state_q)
      SYNC: if (can_pop) begin
        if (rx_data == UPDI_SYNCH) state_d = OPCODE;
        else begin
          ferr_d  = 1'b1;
          state_d = ERROR;
        end
      end
      OPCODE: if (can_pop) begin
        op_d    = rx_data;
        addr_d  = '0;
        state_d = decode_op(rx_data);
        if (state_d == ERROR) ferr_d = 1'b1;
      end
      ADDR: if (can_pop) begin
        case (cnt_q[1:0])
          2'd0:    addr_d[7:0]   = rx_data;
          2'd1:    addr_d[15:8]  = rx_data;
          default: addr_d[23:16] = rx_data;
        endcase
        if (cnt_q == {1'b0, op_q[3:2]}) state_d = (op_q[7:5] == OP_LDS) ? DATA_TX : STS_ACK1;
        else cnt_d = cnt_q + 3'd1;
      end
      DATA_TX: begin
        tx_data  = mem_rdata;
        tx_wr_en = can_push;
        if (can_push) begin
          if (cnt_q == {1'b0, op_q[1:0]}) state_d = SYNC;
          else cnt_d = cnt_q + 3'd1;
        end
      end
      STS_ACK1, STS_ACK2: begin
        tx_data  = UPDI_ACK;
        tx_wr_en = can_push;
        if (can_push) state_d = (state_q == STS_ACK1) ? DATA_RX : SYNC;
      end
      DATA_RX: if (can_pop) begin
        mem_we = 1'b1;
        if (cnt_q == {1'b0, op_q[1:0]}) state_d = STS_ACK2;
        else cnt_d = cnt_q + 3'd1;
      end
      CS_TX: begin
        tx_data  = cs_q[op_q[3:0]];
        tx_wr_en = can_push;
        if (can_push) state_d = SYNC;
      end
      CS_RX: if (can_pop) begin
        if (op_q[3:0] != 4'd0) cs_d[op_q[3:0]] = rx_data;
        state_d = SYNC;
      end
      KEY_RX: if (can_pop) begin
        key_d[{cnt_q, 3'b000} +: 8] = rx_data;
        if (cnt_q == 3'd7) begin
          key_strobe = 1'b1;
          state_d    = SYNC;
        end else cnt_d = cnt_q + 3'd1;
      end
      SIB_TX: begin
        tx_data  = SIB_VALUE[{cnt_q, 3'b000} +: 8];
        tx_wr_en = can_push;
        if (can_push) begin
          if (cnt_q == 3'd7) state_d = SYNC;
          else cnt_d = cnt_q + 3'd1;
        end
      end
      ERROR:   state_d = ERROR;
      default: state_d = SYNC;
    endcase

    if (state_d != state_q) cnt_d = '0;

    // Line reset: abandon the frame; any byte popped this cycle is discarded.
    if (double_break) begin
      state_d    = SYNC;
      cnt_d      = '0;
      ferr_d     = 1'b0;
      key_d      = key_q;
      cs_d       = '0;
      cs_d[0]    = STATUSA_RST;
      mem_we     = 1'b0;
      key_strobe = 1'b0;
      tx_wr_en   = 1'b0;
    end
  end

  assign key_value   = key_q;
  assign frame_error = ferr_q;

endmodule

`default_nettype wire

// File: tb/tb_updi_target_responder.sv
// ============================================================================
// Module : tb_updi_target_responder
// Brief  : Directed self-checking bench with behavioural RX/TX FIFO models.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_updi_target_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        double_break = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_empty = 1'b1;
  logic        rx_rd_en;
  logic [7:0]  tx_data;
  logic        tx_wr_en;
  logic        tx_full = 1'b0;
  logic        key_strobe;
  logic [63:0] key_value;
  logic        frame_error;
  logic [7:0]  dbg_addr = 8'h00;
  logic [7:0]  dbg_data;

  int n_tests = 0;
  int n_fail  = 0;
  int n_ks    = 0;
  int n_full_push = 0;

  logic [7:0] rxq[$];
  logic [7:0] txq[$];

  always #5 clk = ~clk;

  updi_target_responder dut (
    .clk          (clk),
    .rst          (rst),
    .double_break (double_break),
    .rx_data      (rx_data),
    .rx_empty     (rx_empty),
    .rx_rd_en     (rx_rd_en),
    .tx_data      (tx_data),
    .tx_wr_en     (tx_wr_en),
    .tx_full      (tx_full),
    .key_strobe   (key_strobe),
    .key_value    (key_value),
    .frame_error  (frame_error),
    .dbg_addr     (dbg_addr),
    .dbg_data     (dbg_data)
  );

  function automatic void refresh();
    rx_empty = (rxq.size() == 0);
    rx_data  = rx_empty ? 8'h00 : rxq[0];
  endfunction

  // FIFO models: handshakes sampled 1 ns before the rising edge, applied 1 ns after.
  initial begin
    logic       s_pop, s_push, s_full, s_ks;
    logic [7:0] s_txd;
    forever begin
      @(negedge clk);
      #4;
      s_pop  = rx_rd_en;
      s_push = tx_wr_en;
      s_txd  = tx_data;
      s_full = tx_full;
      s_ks   = key_strobe;
      @(posedge clk);
      #1;
      if (s_pop && rxq.size() > 0) begin
        void'(rxq.pop_front());
        refresh();
      end
      if (s_push) begin
        txq.push_back(s_txd);
        if (s_full) n_full_push++;
      end
      if (s_ks) n_ks++;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_rx(input logic [63:0] bytes, input int n);
    for (int i = 0; i < n; i++) rxq.push_back(bytes[i*8 +: 8]);
    refresh();
  endtask

  task automatic drain(input string tag);
    int k;
    k = 0;
    while (rxq.size() != 0 && k < 400) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_rx_drained"}, 64'(rxq.size() == 0), 64'd1);
    repeat (12) @(negedge clk);
  endtask

  task automatic expect_tx(input string tag, input logic [63:0] bytes, input int n);
    check({tag, "_tx_count"}, 64'(txq.size()), 64'(n));
    for (int i = 0; i < n && i < txq.size(); i++)
      check($sformatf("%s_tx[%0d]", tag, i), 64'(txq[i]), 64'(bytes[i*8 +: 8]));
    txq.delete();
  endtask

  task automatic pulse_break();
    @(negedge clk);
    double_break = 1'b1;
    @(negedge clk);
    double_break = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_rx_rd_en",    64'(rx_rd_en),    64'd0);
    check("rst_tx_wr_en",    64'(tx_wr_en),    64'd0);
    check("rst_key_strobe",  64'(key_strobe),  64'd0);
    check("rst_frame_error", 64'(frame_error), 64'd0);
    check("rst_key_value",   key_value,        64'd0);

    // STCS cs3=A5 then LDCS cs3
    push_rx(64'h83_55_A5_C3_55, 5);
    drain("stcs_ldcs");
    expect_tx("stcs_ldcs", 64'hA5, 1);
    check("stcs_frame_error", 64'(frame_error), 64'd0);

    push_rx(64'h80_55, 2);
    drain("ldcs_statusa");
    expect_tx("ldcs_statusa", 64'h30, 1);
    push_rx(64'h80_55_FF_C0_55, 5);
    drain("statusa_ro");
    expect_tx("statusa_ro", 64'h30, 1);

    // STS word at 0x0010
    push_rx(64'h00_10_45_55, 4);
    drain("sts_hdr");
    expect_tx("sts_ack1", 64'h40, 1);
    push_rx(64'h12_34, 2);
    drain("sts_data");
    expect_tx("sts_ack2", 64'h40, 1);
    dbg_addr = 8'h10; #1;
    check("mem_10", 64'(dbg_data), 64'h34);
    dbg_addr = 8'h11; #1;
    check("mem_11", 64'(dbg_data), 64'h12);
    push_rx(64'h00_10_05_55, 4);
    drain("lds_word");
    expect_tx("lds_word", 64'h12_34, 2);

    // STS word at 0xFF wraps to 0x00; ACK1 held off by tx_full
    tx_full = 1'b1;
    push_rx(64'hFF_41_55, 3);
    drain("wrap_hdr");
    repeat (5) begin
      @(negedge clk);
      check("full_no_wr_en", 64'(tx_wr_en), 64'd0);
    end
    check("full_no_tx", 64'(txq.size()), 64'd0);
    tx_full = 1'b0;
    repeat (4) @(negedge clk);
    expect_tx("wrap_ack1", 64'h40, 1);
    push_rx(64'hBB_AA, 2);
    drain("wrap_data");
    expect_tx("wrap_ack2", 64'h40, 1);
    dbg_addr = 8'hFF; #1;
    check("mem_ff", 64'(dbg_data), 64'hAA);
    dbg_addr = 8'h00; #1;
    check("mem_00", 64'(dbg_data), 64'hBB);
    push_rx(64'hFF_01_55, 3);
    drain("wrap_lds");
    expect_tx("wrap_lds", 64'hBB_AA, 2);
    check("no_push_while_full", 64'(n_full_push), 64'd0);

    // KEY then SIB
    n_ks = 0;
    push_rx(64'hE0_55, 2);
    push_rx(64'h4E564D50726F6720, 8);
    drain("key");
    check("key_strobe_count", 64'(n_ks), 64'd1);
    check("key_value", key_value, 64'h4E564D50726F6720);
    expect_tx("key_no_tx", 64'h0, 0);
    push_rx(64'hE4_55, 2);
    drain("sib");
    expect_tx("sib", 64'h2020202020525641, 8);

    // Illegal opcode, discard until double break
    push_rx(64'hA0_55, 2);
    drain("err_op");
    check("err_frame_error", 64'(frame_error), 64'd1);
    push_rx(64'h33_22_11, 3);
    drain("err_discard");
    expect_tx("err_no_tx", 64'h0, 0);
    check("err_sticky", 64'(frame_error), 64'd1);
    pulse_break();
    check("break_clears_err", 64'(frame_error), 64'd0);
    push_rx(64'h80_55, 2);
    drain("recover");
    expect_tx("recover", 64'h30, 1);
    push_rx(64'h83_55, 2);
    drain("cs3_cleared");
    expect_tx("cs3_cleared", 64'h00, 1);

    // Break while STS is waiting for its data byte
    push_rx(64'h10_40_55, 3);
    drain("midsts_hdr");
    expect_tx("midsts_ack1", 64'h40, 1);
    pulse_break();
    push_rx(64'h80_55, 2);
    drain("midsts_recover");
    expect_tx("midsts_recover", 64'h30, 1);
    dbg_addr = 8'h10; #1;
    check("midsts_mem_kept", 64'(dbg_data), 64'h34);
    check("key_kept", key_value, 64'h4E564D50726F6720);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
